// File: rtl/multi_timer_if.sv
// Control and status bundle for multi_timer. The timer is the slave side;
// the controlling logic (or a bench) is the master side.
interface multi_timer_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 25
);
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       stop;
    logic [NCH-1:0]       mode;
    logic [NCH*WIDTH-1:0] limit;
    logic [NCH-1:0]       flag_clr;
    logic [NCH-1:0]       pulse_out;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       flag;
    logic [NCH*WIDTH-1:0] count;

    modport master (
        output en, start, stop, mode, limit, flag_clr,
        input  pulse_out, busy, flag, count
    );

    modport slave (
        input  en, start, stop, mode, limit, flag_clr,
        output pulse_out, busy, flag, count
    );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel interval timer. Each channel counts 0..limit and emits a
// one-cycle terminal pulse, in periodic or one-shot mode, with a sticky
// completion flag.
//
// Handshake: there is no valid/ready pair here. Every control input
// (start, stop, en, flag_clr) is a level sampled on each rising clk edge and
// acts in the cycle it is high; there is no back-pressure, so an input is
// always accepted in the cycle it is presented.
//
// busy is the direct decode of each channel's registered FSM state
// (1 = RUN), so it doubles as the per-channel state debug output.
module multi_timer #(
    parameter int WIDTH = 25,
    parameter int NCH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    multi_timer_if.slave  bus
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [NCH-1:0]       pulse_v;
    logic [NCH-1:0]       busy_v;
    logic [NCH-1:0]       flag_v;
    logic [NCH*WIDTH-1:0] count_v;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] lim;
        logic             mode_q, mode_d;
        logic             flag_q, flag_d;
        logic             term;

        assign lim  = bus.limit[i*WIDTH +: WIDTH];
        // >= rather than == so a limit lowered below the count ends the
        // interval on the next enabled cycle instead of wrapping around.
        assign term = (state_q == S_RUN) && bus.en[i] && (cnt_q >= lim);

        // Next-state and counter update; stop beats start, start beats terminal.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            mode_d  = mode_q;
            if (bus.stop[i]) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (bus.start[i]) begin
                state_d = S_RUN;
                cnt_d   = '0;
                mode_d  = bus.mode[i];
            end else if (state_q == S_RUN && bus.en[i]) begin
                if (term) begin
                    cnt_d = '0;
                    if (mode_q) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        end

        // Sticky flag: a terminal event wins over a same-cycle clear.
        always_comb begin
            flag_d = flag_q;
            if (term) begin
                flag_d = 1'b1;
            end else if (bus.flag_clr[i]) begin
                flag_d = 1'b0;
            end
        end

        // Channel registers with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                mode_q  <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                mode_q  <= mode_d;
                flag_q  <= flag_d;
            end
        end

        assign pulse_v[i]                   = term;
        assign busy_v[i]                    = (state_q == S_RUN);
        assign flag_v[i]                    = flag_q;
        assign count_v[i*WIDTH +: WIDTH]    = cnt_q;
    end

    assign bus.pulse_out = pulse_v;
    assign bus.busy      = busy_v;
    assign bus.flag      = flag_v;
    assign bus.count     = count_v;
endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer (NCH=4, WIDTH=8): reset check, a vector table for
// periodic/one-shot/flag behaviour, hand-written corner sequences, a channel
// independence run and randomized traffic against a reference model.
module tb_multi_timer;
    localparam int N = 4;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_timer_if #(.NCH(N), .WIDTH(W)) bus ();

    multi_timer #(.WIDTH(W), .NCH(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en       = '0;
        bus.start    = '0;
        bus.stop     = '0;
        bus.mode     = '0;
        bus.flag_clr = '0;
    endtask

    task automatic set_lim(input int ch, input logic [W-1:0] v);
        bus.limit[ch*W +: W] = v;
    endtask

    function automatic logic [W-1:0] cnt_of(input int ch);
        return bus.count[ch*W +: W];
    endfunction

    // Stop every channel and clear every flag with no enable, so nothing can
    // fire in this cycle; afterwards all channels are IDLE with count 0 and flag 0.
    task automatic sync_all();
        idle_inputs();
        bus.stop     = '1;
        bus.flag_clr = '1;
        tick();
        idle_inputs();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         ch;
        logic       start;
        logic       stop;
        logic       en;
        logic       mode;
        logic       clr;
        logic [W-1:0] lim;
        logic       e_pulse;
        logic       e_busy;
        logic [W-1:0] e_cnt;
        logic       e_flag;
    } vec_t;

    vec_t vecs [0:16];

    // ---------------- reference model state ----------------
    int m_cnt  [N];
    bit m_run  [N];
    bit m_os   [N];
    bit m_flag [N];

    initial begin
        logic [23:0] solo  [N];
        logic [23:0] joint [N];
        int          lims  [N];
        bit          modes [N];
        logic        any_pulse;

        // ---------------- reset ----------------
        rst = 1'b0;
        idle_inputs();
        bus.limit = '0;
        bus.start = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start = '0;
        #1;
        check("reset busy",  32'(bus.busy),      32'd0);
        check("reset count", 32'(bus.count),     32'd0);
        check("reset flag",  32'(bus.flag),      32'd0);
        check("reset pulse", 32'(bus.pulse_out), 32'd0);

        // ---------------- table-driven vectors ----------------
        //            ch st sp en md cl lim  pulse busy cnt flag
        vecs[0]  = '{0, 1, 0, 1, 0, 0, 3,   0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 0, 0, 3,   0, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 3,   0, 1, 1, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 0, 3,   0, 1, 2, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 0, 3,   1, 1, 3, 0};
        vecs[5]  = '{0, 0, 0, 1, 0, 0, 3,   0, 1, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 0, 0, 3,   0, 1, 1, 1};
        vecs[7]  = '{0, 0, 0, 1, 0, 1, 3,   0, 1, 2, 1};
        vecs[8]  = '{0, 0, 0, 1, 0, 1, 3,   1, 1, 3, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 0, 3,   0, 1, 0, 1};
        vecs[10] = '{0, 0, 1, 1, 0, 0, 3,   0, 1, 1, 1};
        vecs[11] = '{0, 0, 0, 1, 0, 0, 3,   0, 0, 0, 1};
        vecs[12] = '{1, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0};
        vecs[13] = '{1, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0};
        vecs[14] = '{1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1};
        vecs[15] = '{1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1};
        vecs[16] = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0};

        sync_all();
        for (int r = 0; r < 17; r++) begin
            int c;
            c = vecs[r].ch;
            idle_inputs();
            set_lim(c, vecs[r].lim);
            bus.start[c]    = vecs[r].start;
            bus.stop[c]     = vecs[r].stop;
            bus.en[c]       = vecs[r].en;
            bus.mode[c]     = vecs[r].mode;
            bus.flag_clr[c] = vecs[r].clr;
            #1;
            check($sformatf("vec%0d pulse", r), 32'(bus.pulse_out[c]), 32'(vecs[r].e_pulse));
            check($sformatf("vec%0d busy", r),  32'(bus.busy[c]),      32'(vecs[r].e_busy));
            check($sformatf("vec%0d count", r), 32'(cnt_of(c)),        32'(vecs[r].e_cnt));
            check($sformatf("vec%0d flag", r),  32'(bus.flag[c]),      32'(vecs[r].e_flag));
            tick();
        end

        // ---------------- one-shot, ch1 limit 5 ----------------
        sync_all();
        set_lim(1, 5);
        bus.start[1] = 1'b1;
        bus.mode[1]  = 1'b1;
        bus.en[1]    = 1'b1;
        tick();
        bus.start[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("os5 count%0d", k), 32'(cnt_of(1)), 32'(k));
            check($sformatf("os5 nopulse%0d", k), 32'(bus.pulse_out[1]), 32'd0);
            tick();
        end
        #1;
        check("os5 pulse", 32'(bus.pulse_out[1]), 32'd1);
        check("os5 count5", 32'(cnt_of(1)), 32'd5);
        tick();
        #1;
        check("os5 busy after", 32'(bus.busy[1]), 32'd0);
        check("os5 count after", 32'(cnt_of(1)), 32'd0);
        any_pulse = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            any_pulse = any_pulse | bus.pulse_out[1];
        end
        check("os5 no more pulses", 32'(any_pulse), 32'd0);

        // ---------------- pause / restart / start+stop, ch2 limit 10 ----------------
        sync_all();
        set_lim(2, 10);
        bus.start[2] = 1'b1;
        bus.en[2]    = 1'b1;
        tick();
        bus.start[2] = 1'b0;
        repeat (4) tick();
        check("pause count4", 32'(cnt_of(2)), 32'd4);
        bus.en[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("pause hold%0d", k), 32'(cnt_of(2)), 32'd4);
            check($sformatf("pause nopulse%0d", k), 32'(bus.pulse_out[2]), 32'd0);
        end
        bus.en[2] = 1'b1;
        repeat (3) tick();
        check("resume count7", 32'(cnt_of(2)), 32'd7);
        bus.start[2] = 1'b1;
        tick();
        bus.start[2] = 1'b0;
        check("restart count", 32'(cnt_of(2)), 32'd0);
        check("restart busy", 32'(bus.busy[2]), 32'd1);
        repeat (2) tick();
        bus.start[2] = 1'b1;
        bus.stop[2]  = 1'b1;
        tick();
        idle_inputs();
        check("start+stop busy", 32'(bus.busy[2]), 32'd0);
        check("start+stop count", 32'(cnt_of(2)), 32'd0);

        // ---------------- live limit change, ch3 ----------------
        sync_all();
        set_lim(3, 20);
        bus.start[3] = 1'b1;
        bus.en[3]    = 1'b1;
        tick();
        bus.start[3] = 1'b0;
        repeat (8) tick();
        check("live count8", 32'(cnt_of(3)), 32'd8);
        check("live nopulse", 32'(bus.pulse_out[3]), 32'd0);
        set_lim(3, 5);
        #1;
        check("live pulse", 32'(bus.pulse_out[3]), 32'd1);
        tick();
        check("live wrap count", 32'(cnt_of(3)), 32'd0);
        check("live still busy", 32'(bus.busy[3]), 32'd1);
        repeat (5) tick();
        check("live next pulse", 32'(bus.pulse_out[3]), 32'd1);

        // ---------------- channel independence ----------------
        lims  = '{3, 5, 2, 7};
        modes = '{0, 1, 0, 1};
        // Expected pulse pattern from the interval rule: k cycles after the
        // start edge, periodic fires when k mod (L+1) == L, one-shot only at k == L.
        for (int c = 0; c < N; c++) begin
            logic [31:0] pat;
            pat = '0;
            for (int k = 0; k < 24; k++) begin
                if (modes[c]) pat[k] = (k == lims[c]);
                else          pat[k] = ((k % (lims[c] + 1)) == lims[c]);
            end
            exp_q.push_back(pat);
        end
        for (int c = 0; c < N; c++) begin
            sync_all();
            for (int j = 0; j < N; j++) set_lim(j, W'(lims[j]));
            bus.start[c] = 1'b1;
            bus.mode[c]  = modes[c];
            bus.en[c]    = 1'b1;
            tick();
            bus.start[c] = 1'b0;
            for (int k = 0; k < 24; k++) begin
                solo[c][k] = bus.pulse_out[c];
                tick();
            end
        end
        sync_all();
        for (int c = 0; c < N; c++) begin
            bus.start[c] = 1'b1;
            bus.mode[c]  = modes[c];
            bus.en[c]    = 1'b1;
        end
        tick();
        bus.start = '0;
        for (int k = 0; k < 24; k++) begin
            for (int c = 0; c < N; c++) joint[c][k] = bus.pulse_out[c];
            tick();
        end
        for (int c = 0; c < N; c++) begin
            logic [31:0] pat;
            pat = exp_q.pop_front();
            check($sformatf("solo ch%0d", c),  32'(solo[c]),  pat);
            check($sformatf("joint ch%0d", c), 32'(joint[c]), pat);
        end

        // ---------------- randomized traffic vs reference model ----------------
        sync_all();
        for (int c = 0; c < N; c++) begin
            m_cnt[c] = 0; m_run[c] = 0; m_os[c] = 0; m_flag[c] = 0;
            set_lim(c, W'($urandom_range(0, 12)));
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N-1:0]   e_pulse, e_busy, e_flag;
            logic [N*W-1:0] e_count;
            idle_inputs();
            for (int c = 0; c < N; c++) begin
                bus.start[c]    = ($urandom_range(0, 19) == 0);
                bus.stop[c]     = ($urandom_range(0, 39) == 0);
                bus.en[c]       = ($urandom_range(0, 5) != 0);
                bus.mode[c]     = 1'($urandom_range(0, 1));
                bus.flag_clr[c] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 29) == 0) set_lim(c, W'($urandom_range(0, 15)));
            end
            #1;
            for (int c = 0; c < N; c++) begin
                int lim;
                lim = int'(cnt_lim(c));
                e_pulse[c] = m_run[c] && bus.en[c] && (m_cnt[c] >= lim);
                e_busy[c]  = m_run[c];
                e_flag[c]  = m_flag[c];
                e_count[c*W +: W] = W'(m_cnt[c]);
            end
            check($sformatf("rand%0d pulse", cyc), 32'(bus.pulse_out), 32'(e_pulse));
            check($sformatf("rand%0d busy", cyc),  32'(bus.busy),      32'(e_busy));
            check($sformatf("rand%0d flag", cyc),  32'(bus.flag),      32'(e_flag));
            check($sformatf("rand%0d count", cyc), 32'(bus.count),     32'(e_count));
            for (int c = 0; c < N; c++) begin
                if (e_pulse[c])          m_flag[c] = 1;
                else if (bus.flag_clr[c]) m_flag[c] = 0;
                if (bus.stop[c]) begin
                    m_run[c] = 0;
                    m_cnt[c] = 0;
                end else if (bus.start[c]) begin
                    m_run[c] = 1;
                    m_cnt[c] = 0;
                    m_os[c]  = bus.mode[c];
                end else if (e_pulse[c]) begin
                    m_cnt[c] = 0;
                    if (m_os[c]) m_run[c] = 0;
                end else if (m_run[c] && bus.en[c]) begin
                    m_cnt[c] = (m_cnt[c] + 1) % (1 << W);
                end
            end
            tick();
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic logic [W-1:0] cnt_lim(input int ch);
        return bus.limit[ch*W +: W];
    endfunction
endmodule
